latch_write_arbiter: RTL and testbench

LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

---
 rtl/latch_write_arbiter_if.sv | 25 ++
 rtl/latch_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_latch_write_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/latch_write_arbiter_if.sv
// latch_write_arbiter_if: request/grant bus and shared latch-bank signals of the latch write
// arbiter. The master modport is the requester/latch-bank side and the slave modport is the arbiter.
interface latch_write_arbiter_if #(
  parameter int unsigned DW = 8
) ();
  logic [3:0]      req;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt;
  logic [3:0]      done;
  logic            busy;
  logic            latch_e;
  logic [DW-1:0]   latch_d;
  logic [DW-1:0]   latch_q;
  logic            err;

  modport master (
    output req, wdata, latch_q,
    input  gnt, done, busy, latch_e, latch_d, err
  );

  modport slave (
    input  req, wdata, latch_q,
    output gnt, done, busy, latch_e, latch_d, err
  );
endinterface

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: round-robin arbiter for four requesters that sequences each write into a
// shared D-latch bank as SETUP (1 cycle), ENABLE (EN_CYCLES cycles), HOLD (1 cycle), then IDLE.
// All outputs come straight from flops. Optional feature macro READBACK_CHECK_EN: when defined,
// latch_q is compared with latch_d during HOLD and a mismatch sets a sticky err; when undefined
// err is tied low and latch_q is ignored.
module latch_write_arbiter #(
  parameter int unsigned DW        = 8,
  parameter int unsigned EN_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  latch_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StEnable, StHold} state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    done_q, done_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    win_q, win_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] ld_q, ld_d;
  logic          latch_e_q, latch_e_d;
  logic          busy_q, busy_d;

  logic [1:0]    rr_idx;
  logic [1:0]    pick;
  logic          pick_vld;

  // Round-robin search: first requester at or after ptr (mod 4) wins.
  always_comb begin
    rr_idx   = ptr_q;
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = ptr_q + 2'(i);
      if (!pick_vld && bus.req[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation for the write sequence.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 4'b0000;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ld_d      = ld_q;
    latch_e_d = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StSetup;
          win_d   = pick;
          gnt_d   = 4'b0001 << pick;
          ld_d    = bus.wdata[int'(pick)*DW +: DW];
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        state_d   = StEnable;
        cnt_d     = 4'd0;
        latch_e_d = 1'b1;
      end
      StEnable: begin
        if (cnt_q == 4'(EN_CYCLES - 1)) begin
          state_d = StHold;
          done_d  = gnt_q;
        end else begin
          cnt_d     = cnt_q + 4'd1;
          latch_e_d = 1'b1;
        end
      end
      StHold: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        ptr_d   = win_q + 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= 4'b0000;
      done_q    <= 4'b0000;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      cnt_q     <= 4'd0;
      ld_q      <= '0;
      latch_e_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ld_q      <= ld_d;
      latch_e_q <= latch_e_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.latch_e = latch_e_q;
  assign bus.latch_d = ld_q;

`ifdef READBACK_CHECK_EN
  logic err_q;

  // Sticky readback flag: the bank must reflect latch_d while it is held in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StHold && bus.latch_q != ld_q) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_latch_q;
  assign unused_latch_q = ^bus.latch_q;
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter: directed self-checking bench for latch_write_arbiter (EN_CYCLES = 2).
// A transaction here is SETUP + EN_CYCLES enable cycles + HOLD, followed by one IDLE cycle.
module tb_latch_write_arbiter;
  localparam int unsigned DW        = 8;
  localparam int unsigned EN_CYCLES = 2;
`ifdef READBACK_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  latch_write_arbiter_if #(.DW(DW)) bus ();

  latch_write_arbiter #(
    .DW       (DW),
    .EN_CYCLES(EN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural latch bank, optionally stuck at zero.
  logic [DW-1:0] lat_model;
  logic          force_zero;
  always_latch begin
    if (bus.latch_e) lat_model <= bus.latch_d;
  end
  assign bus.latch_q = force_zero ? '0 : lat_model;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Per-cycle observation counters, sampled 1 time unit after each rising edge.
  int            busy_cnt, le_cnt, done_cnt, rise_cnt, d_bad;
  logic [3:0]    done_seen, prev_gnt;
  logic [DW-1:0] exp_d;

  task automatic clr();
    busy_cnt  = 0;
    le_cnt    = 0;
    done_cnt  = 0;
    rise_cnt  = 0;
    d_bad     = 0;
    done_seen = 4'b0000;
    prev_gnt  = bus.gnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.busy) busy_cnt++;
    if (bus.latch_e) le_cnt++;
    if (bus.done != 4'b0000) begin
      done_cnt++;
      done_seen = bus.done;
    end
    if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) rise_cnt++;
    if (bus.busy && bus.latch_d !== exp_d) d_bad++;
    prev_gnt = bus.gnt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]    rr_gnt [5];
    logic [DW-1:0] rr_dat [5];
    int            ng, idle_run;
    logic [3:0]    my_prev;

    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    rst        = 1'b1;
    bus.req    = 4'b0000;
    bus.wdata  = '0;
    force_zero = 1'b0;
    exp_d      = '0;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_latch_e", 32'(bus.latch_e), 32'h0);
    check("rst_latch_d", 32'(bus.latch_d), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request from requester 0.
    bus.wdata[7:0] = 8'hA5;
    exp_d          = 8'hA5;
    clr();
    bus.req = 4'b0001;
    tick();
    check("single_gnt", 32'(bus.gnt), 32'h1);
    check("single_setup_le", 32'(bus.latch_e), 32'h0);
    check("single_setup_d", 32'(bus.latch_d), 32'hA5);
    bus.req = 4'b0000;
    repeat (6) tick();
    check("single_busy_cycles", 32'(busy_cnt), 32'(EN_CYCLES + 2));
    check("single_le_cycles", 32'(le_cnt), 32'(EN_CYCLES));
    check("single_done_count", 32'(done_cnt), 32'd1);
    check("single_done_bit", 32'(done_seen), 32'h1);
    check("single_d_stable", 32'(d_bad), 32'd0);
    check("single_idle_busy", 32'(bus.busy), 32'h0);
    check("single_idle_gnt", 32'(bus.gnt), 32'h0);
    check("single_d_retained", 32'(bus.latch_d), 32'hA5);

    // All four requesting from ptr = 0.
    do_reset();
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req   = 4'b1111;
    clr();
    ng       = 0;
    idle_run = 0;
    my_prev  = bus.gnt;
    for (int t = 0; t < 40 && ng < 5; t++) begin
      tick();
      if (bus.gnt != 4'b0000 && my_prev == 4'b0000) begin
        check($sformatf("rr_gnt%0d", ng), 32'(bus.gnt), 32'(rr_gnt[ng]));
        check($sformatf("rr_data%0d", ng), 32'(bus.latch_d), 32'(rr_dat[ng]));
        if (ng > 0) check($sformatf("rr_gap%0d", ng), 32'(idle_run), 32'd1);
        ng++;
        idle_run = 0;
      end else if (!bus.busy) begin
        idle_run++;
      end
      my_prev = bus.gnt;
    end
    check("rr_grant_count", 32'(ng), 32'd5);
    bus.req = 4'b0000;
    repeat (6) tick();

    // Requester 2 withdraws during ENABLE (ptr is now 1).
    bus.wdata[23:16] = 8'h5A;
    exp_d            = 8'h5A;
    clr();
    bus.req = 4'b0100;
    tick();
    check("wd_gnt", 32'(bus.gnt), 32'h4);
    tick();
    check("wd_enable", 32'(bus.latch_e), 32'h1);
    bus.req = 4'b0000;
    repeat (7) tick();
    check("wd_le_cycles", 32'(le_cnt), 32'(EN_CYCLES));
    check("wd_done_count", 32'(done_cnt), 32'd1);
    check("wd_done_bit", 32'(done_seen), 32'h4);
    check("wd_no_regrant", 32'(rise_cnt), 32'd1);
    check("wd_idle_busy", 32'(bus.busy), 32'h0);

    // Serve requester 1 so that ptr becomes 2.
    bus.req = 4'b0010;
    tick();
    check("r1_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    repeat (5) tick();

    // Reset during ENABLE; ptr must restart at 0 (0110 then picks 1, not 2).
    clr();
    bus.req = 4'b0001;
    tick();
    check("ab_gnt", 32'(bus.gnt), 32'h1);
    tick();
    check("ab_enable", 32'(bus.latch_e), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ab_async_le", 32'(bus.latch_e), 32'h0);
    check("ab_async_gnt", 32'(bus.gnt), 32'h0);
    check("ab_async_busy", 32'(bus.busy), 32'h0);
    check("ab_async_done", 32'(bus.done), 32'h0);
    bus.req = 4'b0110;
    @(posedge clk);
    #1;
    check("ab_rst_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    tick();
    check("ab_first_after_rst", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    repeat (5) tick();
    check("ab_done_count", 32'(done_cnt), 32'd1);
    check("ab_done_bit", 32'(done_seen), 32'h2);
    check("err_clean", 32'(bus.err), 32'h0);

    // Readback with a stuck-at-zero latch bank.
    bus.wdata[7:0] = 8'h3C;
    force_zero     = 1'b1;
    bus.req        = 4'b0001;
    tick();
    bus.req = 4'b0000;
    repeat (4) tick();
    check("rb_latch_d", 32'(bus.latch_d), 32'h3C);
    check("rb_err_rise", 32'(bus.err), 32'(EXP_ERR));
    repeat (3) tick();
    check("rb_err_sticky", 32'(bus.err), 32'(EXP_ERR));
    do_reset();
    check("rb_err_rst", 32'(bus.err), 32'h0);
    force_zero = 1'b0;
    bus.req    = 4'b0001;
    tick();
    bus.req = 4'b0000;
    repeat (5) tick();
    check("rb_err_good_latch", 32'(bus.err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
